// File: rtl/extio8x4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : extio8x4_pkg
// Description : Shared widths, link-state encoding and byte-assembly helper
//               for the extio8x4 nibble link. The state typedef is common to
//               the initiator and target blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package extio8x4_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    // Nibble position within the byte currently being transferred.
    typedef enum logic [0:0] {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } extio8x4_state_t;

    // Combine the held first nibble with the second nibble on the wire.
    function automatic logic [BYTE_W-1:0] assemble_byte(
        input logic                lsb_first,
        input logic [NIBBLE_W-1:0] first_nib,
        input logic [NIBBLE_W-1:0] second_nib
    );
        if (lsb_first) begin
            return {second_nib, first_nib};
        end
        return {first_nib, second_nib};
    endfunction

endpackage : extio8x4_pkg
`default_nettype wire

// File: rtl/extio8x4_rx_buf.sv
`default_nettype none
// ============================================================================
// Module      : extio8x4_rx_buf
// Description : Output buffer driving an 8-bit AXI-Stream master.
//               Default build : a single output register.
//               EXTIO8X4_TARGET_SKID_EN defined : a 2-entry FIFO, so one more
//               byte can be accepted while downstream stalls.
// Ports       : clk, reset (async, active-high)
//               load / load_data : push one byte (only when slot_free = 1)
//               slot_free        : a push at this edge will be accepted
//               m_axis_tdata / m_axis_tvalid / m_axis_tready : AXIS master
// Revision    : 1.0 - initial release
// ============================================================================
module extio8x4_rx_buf
    import extio8x4_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    output logic              slot_free,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);

`ifdef EXTIO8X4_TARGET_SKID_EN

    logic [BYTE_W-1:0] r_ent0;
    logic [BYTE_W-1:0] r_ent1;
    logic              r_head;
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_wr_idx;

    assign w_pop     = (r_count != 2'd0) && m_axis_tready;
    // A push while full is only possible together with a pop; it then lands
    // in the slot being vacated, which becomes the tail once head advances.
    assign w_wr_idx  = r_head ^ r_count[0];
    assign slot_free = !r_count[1] || m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (load) begin
                if (w_wr_idx) begin
                    r_ent1 <= load_data;
                end else begin
                    r_ent0 <= load_data;
                end
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({load, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_axis_tdata  = r_head ? r_ent1 : r_ent0;
    assign m_axis_tvalid = (r_count != 2'd0);

`else

    logic [BYTE_W-1:0] r_data;
    logic              r_valid;

    assign slot_free = !r_valid || m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (load) begin
                // Covers the back-to-back case: a handshake and a new byte at
                // the same edge keep tvalid high with no bubble.
                r_data  <= load_data;
                r_valid <= 1'b1;
            end else if (m_axis_tready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;

`endif

endmodule : extio8x4_rx_buf
`default_nettype wire

// File: rtl/extio8x4_axis_target.sv
`default_nettype none
// ============================================================================
// Module      : extio8x4_axis_target
// Description : Receive side of the extio8x4 nibble link. Takes the
//               synchronised request toggle and the 4-bit data plane, returns
//               a toggle acknowledge, and assembles nibble pairs into bytes on
//               an AXI-Stream master. Downstream backpressure is pushed onto
//               the link by withholding the acknowledge of the second nibble.
//               Optional macro EXTIO8X4_TARGET_SKID_EN selects a 2-entry
//               output buffer instead of a single register.
// Parameters  : LSB_FIRST - 1: first nibble is [3:0]; 0: first nibble is [7:4]
//               ACK_INIT  - reset value of ack_o (matches initiator req reset)
// Ports       : clk, reset (async, active-high)
//               req_s   : synchronised request toggle
//               data4_i : nibble, stable while req_s != ack_o
//               ack_o   : registered acknowledge toggle
//               m_axis_tdata / m_axis_tvalid / m_axis_tready : AXIS master
// Revision    : 1.0 - initial release
// ============================================================================
module extio8x4_axis_target
    import extio8x4_pkg::*;
#(
    parameter int   LSB_FIRST = 1,
    parameter logic ACK_INIT  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_s,
    input  logic [NIBBLE_W-1:0] data4_i,
    output logic                ack_o,
    output logic [BYTE_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready
);

    extio8x4_state_t     r_state;
    extio8x4_state_t     w_state_next;
    logic                r_ack;
    logic [NIBBLE_W-1:0] r_hold;

    logic                w_pending;
    logic                w_slot_free;
    logic                w_capture;
    logic                w_toggle;
    logic                w_load;
    logic [BYTE_W-1:0]   w_byte;

    // A new nibble is on the wire whenever the request toggle differs from
    // our last acknowledge; toggling ack clears this on the next cycle.
    assign w_pending = (req_s != r_ack);
    assign w_byte    = assemble_byte(LSB_FIRST != 0, r_hold, data4_i);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_toggle     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            FIRST: begin
                if (w_pending) begin
                    w_capture    = 1'b1;
                    w_toggle     = 1'b1;
                    w_state_next = SECOND;
                end
            end
            SECOND: begin
                // Without room downstream the second nibble stays un-acked,
                // which holds the initiator off.
                if (w_pending && w_slot_free) begin
                    w_load       = 1'b1;
                    w_toggle     = 1'b1;
                    w_state_next = FIRST;
                end
            end
            default: begin
                w_state_next = FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FIRST;
            r_ack   <= ACK_INIT;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_toggle) begin
                r_ack <= ~r_ack;
            end
            if (w_capture) begin
                r_hold <= data4_i;
            end
        end
    end

    assign ack_o = r_ack;

    extio8x4_rx_buf u_rx_buf (
        .clk           (clk),
        .reset         (reset),
        .load          (w_load),
        .load_data     (w_byte),
        .slot_free     (w_slot_free),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule : extio8x4_axis_target
`default_nettype wire
